// File: rtl/bus_cycle_ctl_if.sv
// Signal bundle between the 6502 bus cycle controller and the CPU/decoder/config side.
// The controller owns phi2 and the RAM strobes; everything else is driven toward it.
interface bus_cycle_ctl_if #(
   parameter int unsigned WS_W = 3
);
   logic            rw;
   logic            ram_cs;
   logic            sid_cs;
   logic            via1_cs;
   logic            via2_cs;
   logic            uart_cs;
   logic            bifrost_cs;
   logic            cfg_we;
   logic [2:0]      cfg_sel;
   logic [WS_W-1:0] cfg_ws;
   logic            phi2;
   logic            ram_oe_n;
   logic            ram_we_n;
   logic            cycle_start;
   logic            stretched;

   modport master (
      input  rw, ram_cs, sid_cs, via1_cs, via2_cs, uart_cs, bifrost_cs,
      input  cfg_we, cfg_sel, cfg_ws,
      output phi2, ram_oe_n, ram_we_n, cycle_start, stretched
   );

   modport slave (
      output rw, ram_cs, sid_cs, via1_cs, via2_cs, uart_cs, bifrost_cs,
      output cfg_we, cfg_sel, cfg_ws,
      input  phi2, ram_oe_n, ram_we_n, cycle_start, stretched
   );
endinterface

// File: rtl/bus_cycle_ctl.sv
// 6502 bus cycle controller: derives phi2 from the system clock, samples chip selects
// once per cycle and stretches phi2-high by a per-device wait-state count.
module bus_cycle_ctl #(
   parameter int unsigned DIV  = 4,
   parameter int unsigned WS_W = 3
) (
   input logic             clock,
   input logic             reset_n,
   bus_cycle_ctl_if.master bus
);
   localparam int unsigned   CW       = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   typedef enum logic [1:0] {PH1, PH2, STRETCH} state_t;
   typedef enum logic [2:0] {
      DEV_RAM, DEV_SID, DEV_VIA1, DEV_VIA2, DEV_UART, DEV_BIFROST, DEV_NONE = 3'd7
   } dev_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   dev_t            sel_q;
   logic            rw_q;
   logic [WS_W-1:0] wait_q;
   logic [WS_W-1:0] ws_tab [6];

   dev_t            sel_now;
   logic [WS_W-1:0] ws_now;
   logic            cnt_last;
   logic            sample;
   logic            leave_hi;
   logic            hi_d;
   dev_t            sel_d;
   logic            rw_d;

   always_comb begin
      sel_now = DEV_NONE;
      if (!bus.bifrost_cs)   sel_now = DEV_BIFROST;
      else if (!bus.uart_cs) sel_now = DEV_UART;
      else if (!bus.via2_cs) sel_now = DEV_VIA2;
      else if (!bus.via1_cs) sel_now = DEV_VIA1;
      else if (!bus.sid_cs)  sel_now = DEV_SID;
      else if (!bus.ram_cs)  sel_now = DEV_RAM;
   end

   always_comb begin
      ws_now = '0;
      if (sel_now != DEV_NONE) ws_now = ws_tab[sel_now];
   end

   // Strobes and phi2 are registered from the values the next state will hold,
   // so they change on the same edge as the state transition.
   always_comb begin
      cnt_last = (cnt == CNT_LAST);
      sample   = (state == PH1) && cnt_last;
      leave_hi = cnt_last && (((state == PH2) && (wait_q == '0)) ||
                              ((state == STRETCH) && (wait_q == WS_W'(1))));
      hi_d     = sample || ((state != PH1) && !leave_hi);
      sel_d    = sample ? sel_now : sel_q;
      rw_d     = sample ? bus.rw  : rw_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= PH1;
         cnt             <= '0;
         sel_q           <= DEV_NONE;
         rw_q            <= 1'b1;
         wait_q          <= '0;
         bus.phi2        <= 1'b0;
         bus.ram_oe_n    <= 1'b1;
         bus.ram_we_n    <= 1'b1;
         bus.cycle_start <= 1'b0;
         bus.stretched   <= 1'b0;
      end else begin
         cnt             <= cnt_last ? '0 : cnt + CW'(1);
         sel_q           <= sel_d;
         rw_q            <= rw_d;
         bus.phi2        <= hi_d;
         bus.ram_oe_n    <= !(hi_d && (sel_d == DEV_RAM) && rw_d);
         bus.ram_we_n    <= !(hi_d && (sel_d == DEV_RAM) && !rw_d);
         bus.cycle_start <= (state == PH1) && (cnt == '0);
         if (cnt_last) begin
            unique case (state)
               PH1: begin
                  state  <= PH2;
                  wait_q <= ws_now;
               end
               PH2: begin
                  if (wait_q == '0) begin
                     state <= PH1;
                  end else begin
                     state         <= STRETCH;
                     bus.stretched <= 1'b1;
                  end
               end
               STRETCH: begin
                  wait_q <= wait_q - WS_W'(1);
                  if (wait_q == WS_W'(1)) begin
                     state         <= PH1;
                     bus.stretched <= 1'b0;
                  end
               end
               default: state <= PH1;
            endcase
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ws_tab[0] <= '0;
         ws_tab[1] <= WS_W'(1);
         ws_tab[2] <= '0;
         ws_tab[3] <= '0;
         ws_tab[4] <= WS_W'(2);
         ws_tab[5] <= '0;
      end else if (bus.cfg_we && (bus.cfg_sel <= 3'd5)) begin
         ws_tab[bus.cfg_sel] <= bus.cfg_ws;
      end
   end
endmodule

// File: doc/bus_cycle_ctl.md
# bus_cycle_ctl

Bus cycle controller for the 6502 side of the board. It derives the CPU phi2 from the fast system clock and samples the active-low chip selects from the address decoder once per bus cycle. Using a per-device wait-state table, it stretches the phi2-high phase for slow peripherals (SID, UART). It also produces the gated RAM read/write strobes. Bifröst software programs the wait-state table through a small config port.

## Interface
Parameters:
- DIV, 4, system clocks per base phi2 half-phase; legal values 2..16.
- WS_W, 3, width of each wait-state entry; 0..7 extra half-phases.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rw  in  1  CPU read/write; 1 = read.
- ram_cs, sid_cs, via1_cs, via2_cs, uart_cs, bifrost_cs  in  1 each  active-low selects from the address decoder.
- cfg_we  in  1  wait-state table write strobe.
- cfg_sel  in  3  table index: 0 RAM, 1 SID, 2 VIA1, 3 VIA2, 4 UART, 5 BIFROST; 6 and 7 are ignored.
- cfg_ws  in  WS_W  wait-state value to write.
- phi2  out  1  CPU clock.
- ram_oe_n  out  1  RAM output enable, active-low.
- ram_we_n  out  1  RAM write enable, active-low.
- cycle_start  out  1  one-clock pulse on the first clock of each bus cycle.
- stretched  out  1  high while the phi2-high phase is being extended.

## Operation
- FSM with three states: PH1 (phi2=0), PH2 (phi2=1), STRETCH (phi2=1). A phase counter of width clog2(DIV) counts DIV clocks per state visit.
- PH1 lasts DIV clocks, then goes to PH2. On that transition, sample the selects and latch the selected device index (sel_q) and wait count (wait_q = table[sel_q]).
- Select priority when more than one select is low: bifrost > uart > via2 > via1 > sid > ram. With no select low, sel_q = none and wait_q = 0.
- PH2 lasts DIV clocks. At its end:
  - if wait_q = 0, go to PH1;
  - otherwise go to STRETCH.
- STRETCH lasts DIV clocks per visit and decrements wait_q at the end of each visit. When wait_q reaches 0, go to PH1; otherwise repeat STRETCH.
- ram_oe_n = 0 only in PH2 or STRETCH, with sel_q = RAM and the rw latched at sampling = 1.
- ram_we_n = 0 only in PH2 or STRETCH, with sel_q = RAM and latched rw = 0.
- Both RAM strobes are registered and deassert on the same edge phi2 falls.
- stretched = 1 exactly in STRETCH.
- cycle_start = 1 on the first clock of every PH1.
- Table writes: on cfg_we, table[cfg_sel] <= cfg_ws in one clock. A write takes effect at the next sampling point only; an in-flight wait_q is never modified.
- Table reset values: RAM 0, SID 1, VIA1 0, VIA2 0, UART 2, BIFROST 0.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Reset values: phi2=0, ram_oe_n=1, ram_we_n=1, cycle_start=0, stretched=0; state PH1, phase counter 0, wait_q=0, sel_q=none.
- First cycle_start pulse occurs on the first rising clock after reset_n deasserts.
- Bus cycle length is 2·DIV + wait_q·DIV clocks. With DIV=4: a RAM cycle is 8 clocks; a SID cycle is 12; a UART cycle is 16.
- The phi2 rising edge coincides with the clock that latches sel_q and wait_q. Select changes after that edge do not affect the current cycle.
- Simultaneous cfg_we and sampling edge: the sample uses the old table value; the new value applies from the next cycle.
- If reset_n asserts mid-cycle, including during STRETCH, all outputs return to reset values asynchronously; the table returns to defaults.
- Wait count is bounded by 2^WS_W − 1; the decrement never wraps below 0.

## Test plan
- Reset, DIV=4, ram_cs=0 held, rw=1:
  - phi2 toggles every 4 clocks with a period of 8;
  - cycle_start pulses every 8 clocks;
  - ram_oe_n is low for 4 clocks per cycle;
  - ram_we_n stays 1 and stretched stays 0.
- uart_cs=0 at default table: phi2 is high 12 clocks and low 4; stretched is high for 8 clocks; RAM strobes stay 1.
- Write cfg_sel=1, cfg_ws=3 during a SID cycle that latched wait 1:
  - current cycle phi2-high = 8 clocks;
  - next SID cycle phi2-high = 16 clocks.
- ram_cs=0 and sid_cs=0 together: SID wins with a 12-clock cycle and no RAM strobe.
- rw=0 with ram_cs=0: ram_we_n is low exactly 4 clocks aligned to phi2-high.
- Assert reset_n low during the second STRETCH visit of a UART cycle: immediately phi2=0, stretched=0, RAM strobes=1. After release the UART wait is 2 again, confirming table defaults restored.
